bootmem_ctrl: RTL
=================

Name: bootmem_ctrl

Overview:
Parametrised boot memory for the SoC CPU, replacing the fixed 16-word boot store. It holds a reset-loaded image:
- The low ROM_WORDS words are write-protected. They can only be patched after a two-write unlock key sequence.
- The remaining words are RAM that reloads from the image on reset.
Reads are synchronous with a valid strobe, and the output holds between reads (no latches). It sits on the CPU data bus beside main memory and SPI.

Parameters:
DATA_W, 16, word width
ADDR_W, 4, address width
DEPTH, 11, implemented words (DEPTH <= 2**ADDR_W); addresses >= DEPTH are unmapped
ROM_WORDS, 7, words 0..ROM_WORDS-1 are protected (ROM_WORDS <= DEPTH)
INIT, {F200,4000,F800,F400,B007,6007,4000,0008,0000,0000,0000}, flattened DEPTH*DATA_W reset image; word i = INIT[i*DATA_W +: DATA_W]
KEY_A, 16'h5A5A, first unlock key (DATA_W bits)
KEY_B, 16'hC3C3, second unlock key (DATA_W bits)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
cs  input  1  chip select
we  input  1  1 = write, 0 = read (qualified by cs)
addr  input  ADDR_W  word address
din  input  DATA_W  write data
dout  output  DATA_W  registered read data; holds between reads
dout_valid  output  1  one-cycle pulse, dout updated this cycle
wr_err  output  1  one-cycle pulse on a rejected write
unlocked  output  1  high while the FSM is in UNLOCKED

Behaviour:
Reset (rst low, async):
- mem[i] <= INIT word i for all i < DEPTH.
- dout=0, dout_valid=0, wr_err=0, FSM=LOCKED, unlocked=0.
- Reset asserted mid-sequence aborts it; patched ROM words revert to INIT.

Read (cs & ~we):
- Next edge: dout <= mem[addr], or 0 if addr >= DEPTH; dout_valid=1. Latency 1 cycle.
- Back-to-back reads give one word per cycle.
- Without a read, dout holds and dout_valid=0.
- A read of an address written in the previous cycle returns the new data.
- Reads never change FSM state.

RAM write (cs & we & ROM_WORDS <= addr < DEPTH):
- mem[addr] <= din next edge. Always accepted; FSM unaffected.

Unmapped write (addr >= DEPTH):
- Ignored; wr_err pulses. FSM unaffected.

ROM-region write (addr < ROM_WORDS), FSM with states LOCKED, KEY1, UNLOCKED:
- LOCKED: din==KEY_A -> KEY1. Any other din -> wr_err pulse, stay LOCKED. Memory is never written.
- KEY1: din==KEY_B -> UNLOCKED. Any other din -> wr_err pulse, LOCKED. Memory is not written.
- UNLOCKED: mem[addr] <= din, then LOCKED. This is a single-shot patch. Key values are accepted as data in this state.
- Key writes may target any ROM-region address. The FSM only advances on ROM-region writes, so RAM writes, reads and idle cycles between key writes do not break the sequence.
- unlocked is registered from the FSM: high the cycle after the KEY_B write, low the cycle after the patch write.

General rules:
- wr_err is registered: high exactly the cycle after an offending write, otherwise 0.
- cs low: no state changes except dout_valid/wr_err returning to 0.
- All arithmetic is unsigned. Address compares use full ADDR_W.

Test Plan:
1. Release rst, read addr 0..10 back-to-back. Expect dout F200,4000,F800,F400,B007,6007,4000,0008,0,0,0, each 1 cycle after its request with dout_valid high; then idle, expect dout holding 0000 and dout_valid=0.
2. Write 1234 to addr 8, read addr 8 next cycle. Expect 1234. Write addr 12 -> wr_err pulse; read addr 12 -> 0000.
3. Write BEEF to addr 2 while LOCKED. Expect wr_err pulse and addr 2 still F800. Write 5A5A, then 0000, to addr 0 -> wr_err on the second write, FSM back to LOCKED, unlocked never high.
4. Write 5A5A to addr 0, write 9999 to addr 9 (RAM), then C3C3 to addr 1. Expect unlocked=1 and addr 9 = 9999. Write BEEF to addr 2 -> unlocked falls; read 2 = BEEF. A second write to addr 2 -> wr_err, still BEEF.
5. Unlock, patch addr 4 = 0001, write addr 7 = AAAA, then pulse rst low asynchronously mid-cycle. Expect dout and flags 0 immediately, addr 4 = B007, addr 7 = 0008, unlocked=0.
6. Instantiate DATA_W=8, ADDR_W=3, DEPTH=8, ROM_WORDS=2, KEY_A=A5, KEY_B=3C. Repeat the lock/unlock/patch sequence and check wr_err on writes to addr 0..1 while locked.

Source files
------------

// File: rtl/bootmem_ctrl.sv
// Boot memory with a protected ROM region and a reset-loaded RAM tail.
// ROM-region words can only be patched once after a two-write key sequence.
module bootmem_ctrl #(
    parameter int                       DATA_W    = 16,
    parameter int                       ADDR_W    = 4,
    parameter int                       DEPTH     = 11,
    parameter int                       ROM_WORDS = 7,
    parameter logic [DEPTH*DATA_W-1:0]  INIT      = {16'h0000, 16'h0000, 16'h0000, 16'h0008,
                                                     16'h4000, 16'h6007, 16'hB007, 16'hF400,
                                                     16'hF800, 16'h4000, 16'hF200},
    parameter logic [DATA_W-1:0]        KEY_A     = 16'h5A5A,
    parameter logic [DATA_W-1:0]        KEY_B     = 16'hC3C3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              wr_err,
    output logic              unlocked
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ROM_L   = (ADDR_W+1)'(ROM_WORDS);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              wr_err_q, wr_err_d;
    logic              unlocked_q, unlocked_d;

    logic [ADDR_W:0]   addr_ext;
    logic              mapped;
    logic              in_rom;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        wr_err_d     = 1'b0;
        wr_en        = 1'b0;
        rd_word      = '0;
        addr_ext     = {1'b0, addr};
        mapped       = (addr_ext < DEPTH_L);
        in_rom       = (addr_ext < ROM_L);

        for (int i = 0; i < DEPTH; i++) begin
            if (addr_ext == (ADDR_W+1)'(i)) begin
                rd_word = mem_q[i];
            end
        end

        if (cs) begin
            if (!we) begin
                dout_d       = mapped ? rd_word : '0;
                dout_valid_d = 1'b1;
            end else if (!mapped) begin
                wr_err_d = 1'b1;
            end else if (!in_rom) begin
                wr_en = 1'b1;
            end else begin
                // Key words are never stored; only the UNLOCKED write lands in memory.
                case (state_q)
                    LOCKED: begin
                        if (din == KEY_A) state_d  = KEY1;
                        else              wr_err_d = 1'b1;
                    end
                    KEY1: begin
                        if (din == KEY_B) begin
                            state_d = UNLOCKED;
                        end else begin
                            state_d  = LOCKED;
                            wr_err_d = 1'b1;
                        end
                    end
                    UNLOCKED: begin
                        wr_en   = 1'b1;
                        state_d = LOCKED;
                    end
                    default: state_d = LOCKED;
                endcase
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && addr_ext == (ADDR_W+1)'(i)) begin
                mem_d[i] = din;
            end
        end

        unlocked_d = (state_d == UNLOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LOCKED;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
            unlocked_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT[i*DATA_W +: DATA_W];
            end
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_err_q     <= wr_err_d;
            unlocked_q   <= unlocked_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wr_err     = wr_err_q;
    assign unlocked   = unlocked_q;

endmodule
